axi_rd_arb: RTL and testbench
=============================

AXI_RD_ARB -- requirements
Module: axi_rd_arb

Interface
REQ-001 Parameter TIMEOUT, default 255: cycles waited for a slave R beat before an error response is generated (used only with the timeout feature).
REQ-002 clk  input  1  single clock; every state element changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 arvalid_m  input  2  AR valid per master; bit0 = IFU, bit1 = LSU.
REQ-005 araddr_m  input  64  AR address per master; [31:0] = IFU, [63:32] = LSU.
REQ-006 arready_m  output  2  AR ready per master.
REQ-007 rvalid_m  output  2  R valid per master.
REQ-008 rdata_m  output  32  R data, broadcast to both masters.
REQ-009 rresp_m  output  2  R response, broadcast to both masters.
REQ-010 rready_m  input  2  R ready per master.
REQ-011 araddr / arvalid  output  32 / 1  AR channel to the shared slave.
REQ-012 arready  input  1  slave AR ready.
REQ-013 rdata / rresp / rvalid  input  32 / 2 / 1  slave R channel.
REQ-014 rready  output  1  R ready to the slave.
REQ-015 gnt  output  2  one-hot current owner; 2'b00 when idle.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ADDR, DATA; only one read is outstanding at a time.
REQ-017 IDLE: if any arvalid_m bit is set, pick a winner, assert arready_m for the winner only (combinational, same cycle), latch its address and index, and go to ADDR.
REQ-018 Arbitration SHALL be round-robin: on a tie, the master not granted last wins; with one requester, that requester wins.
REQ-019 ADDR: arvalid=1, araddr=latched address; when arready=1, go to DATA.
REQ-020 DATA: rvalid_m[gnt]=rvalid, rready=rready_m[gnt], rdata_m=rdata, rresp_m=rresp; when rvalid&rready, update last-grant and go to IDLE.
REQ-021 Non-granted master bits of arready_m and rvalid_m SHALL be 0 in every state.
REQ-022 Latency: AR reaches the slave 1 cycle after the master handshake; R forwarding is combinational (0 cycles).
REQ-023 In IDLE, rready SHALL be 1 and any slave R beat SHALL be discarded.
REQ-024 A request that arrives while ADDR/DATA is active waits and is not accepted until IDLE.

Reset
REQ-025 While rst=1: state=IDLE, gnt=0, arvalid=0, araddr=0, arready_m=0, rvalid_m=0, last-grant=LSU (IFU wins the first tie).
REQ-026 Reset mid-transaction SHALL abandon the transaction immediately; no response is delivered to the old owner.

Configuration
REQ-027 Macro AXI_RD_ARB_TIMEOUT_EN defined: an 8-bit+ counter clears on entry to DATA and increments each DATA cycle without rvalid.
- When it reaches TIMEOUT, drive rvalid_m[gnt]=1, rdata_m=0, rresp_m=2'b11, rready=0.
- On rready_m[gnt], go to IDLE; any later slave beat is dropped per REQ-023.
REQ-028 Macro undefined: no counter is instantiated; DATA waits indefinitely for rvalid.

Verification
REQ-029 IFU only, araddr_m[31:0]=0x80000000, slave returns 0x00000413 after 3 cycles -> rvalid_m=2'b01, rdata_m=0x00000413, rresp_m=0, gnt returns to 0.
REQ-030 Both request in the same cycle out of reset -> IFU granted first; LSU granted next; IFU again on a third simultaneous tie.
REQ-031 LSU asserts arvalid while an IFU read is in DATA -> arready_m[1] stays 0 until IDLE, then LSU address 0xa00003f8 appears on araddr one cycle after its handshake.
REQ-032 Master holds rready_m=0 for 4 cycles with slave rvalid=1 -> rready=0, state stays DATA, data stable, completes on the first cycle rready_m=1.
REQ-033 rst pulsed asynchronously mid-DATA -> all outputs reach reset values before the next clk edge; the next request is handled normally.
REQ-034 With AXI_RD_ARB_TIMEOUT_EN and TIMEOUT=8, slave never answers -> on the 8th DATA cycle rvalid_m[gnt]=1 with rresp_m=2'b11 and rdata_m=0; a late slave beat in IDLE is discarded.

Source files
------------

// File: rtl/axi_rd_arb.sv
// Two-master (IFU/LSU) round-robin read arbiter onto one AXI-style slave, one read in flight.
// Optional R-beat timeout: define AXI_RD_ARB_TIMEOUT_EN to enable the error-response counter.
module axi_rd_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  arvalid_m,
    input  logic [63:0] araddr_m,
    output logic [1:0]  arready_m,
    output logic [1:0]  rvalid_m,
    output logic [31:0] rdata_m,
    output logic [1:0]  rresp_m,
    input  logic [1:0]  rready_m,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [1:0]  gnt
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      state;
    logic        last;      // index of the master granted most recently
    logic        win;
    logic [31:0] win_addr;
    logic        own_rready;
    logic        tmo;
    logic        done;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("axi_rd_arb: TIMEOUT must be at least 1");
    end

    // Tie goes to whoever was not granted last; a lone requester always wins.
    always_comb begin
        win        = (arvalid_m == 2'b11) ? ~last : arvalid_m[1];
        win_addr   = win ? araddr_m[63:32] : araddr_m[31:0];
        own_rready = |(rready_m & gnt);
    end

`ifdef AXI_RD_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Counts DATA cycles without a beat; first DATA cycle is cnt==0, so the
    // error fires on DATA cycle number TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (state == ADDR && arready)
            cnt <= '0;
        else if (state == DATA && !rvalid && !tmo)
            cnt <= cnt + 1'b1;
    end

    assign tmo = (state == DATA) && (cnt >= CNT_LAST);
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        arready_m = 2'b00;
        if (state == IDLE && |arvalid_m && !rst)
            arready_m = win ? 2'b10 : 2'b01;
        rvalid_m = (state == DATA) ? (gnt & {2{rvalid | tmo}}) : 2'b00;
        rdata_m  = tmo ? 32'h0 : rdata;
        rresp_m  = tmo ? 2'b11 : rresp;
        case (state)
            IDLE:    rready = 1'b1;   // drain stray beats
            DATA:    rready = own_rready & ~tmo;
            default: rready = 1'b0;
        endcase
        done = (state == DATA) && own_rready && (rvalid || tmo);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 2'b00;
            arvalid <= 1'b0;
            araddr  <= 32'h0;
            last    <= 1'b1;
        end else begin
            case (state)
                IDLE: if (|arvalid_m) begin
                    gnt     <= win ? 2'b10 : 2'b01;
                    araddr  <= win_addr;
                    arvalid <= 1'b1;
                    state   <= ADDR;
                end
                ADDR: if (arready) begin
                    arvalid <= 1'b0;
                    state   <= DATA;
                end
                DATA: if (done) begin
                    last  <= gnt[1];
                    gnt   <= 2'b00;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed bench for axi_rd_arb: arbitration order, forwarding, backpressure, reset, timeout.
module tb_axi_rd_arb;

`ifdef AXI_RD_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  arvalid_m;
    logic [63:0] araddr_m;
    logic [1:0]  arready_m;
    logic [1:0]  rvalid_m;
    logic [31:0] rdata_m;
    logic [1:0]  rresp_m;
    logic [1:0]  rready_m;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [1:0]  gnt;

    int errs = 0;
    int checks = 0;

    axi_rd_arb #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .arvalid_m(arvalid_m), .araddr_m(araddr_m), .arready_m(arready_m),
        .rvalid_m(rvalid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rready_m(rready_m),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .gnt(gnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full read; req stays asserted for the loser so it must wait until IDLE.
    task automatic xact(input string tag, input logic [1:0] req, input logic [1:0] exp_g,
                        input logic [31:0] exp_a, input logic [31:0] d);
        arvalid_m = req;
        #1 chk({tag, "_arready"}, arready_m, exp_g);
        tick();
        arvalid_m = req & ~exp_g;
        #1;
        chk({tag, "_gnt"}, gnt, exp_g);
        chk({tag, "_arvalid"}, arvalid, 1'b1);
        chk({tag, "_araddr"}, araddr, exp_a);
        chk({tag, "_hold_addr"}, arready_m, 2'b00);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk({tag, "_wait_rv"}, rvalid_m, 2'b00);
            chk({tag, "_hold_data"}, arready_m, 2'b00);
            tick();
        end
        rvalid = 1'b1; rdata = d; rresp = 2'b00; rready_m = exp_g;
        #1;
        chk({tag, "_rvalid_m"}, rvalid_m, exp_g);
        chk({tag, "_rdata_m"}, rdata_m, d);
        chk({tag, "_rresp_m"}, rresp_m, 2'b00);
        chk({tag, "_rready"}, rready, 1'b1);
        tick();
        rvalid = 1'b0; rready_m = 2'b00;
        #1;
        chk({tag, "_gnt_idle"}, gnt, 2'b00);
        chk({tag, "_loser_ar"}, arready_m, req & ~exp_g);
    endtask

    // Bring IFU into DATA, leaving the bench 1 cycle after the slave AR handshake.
    task automatic to_data_ifu();
        arvalid_m = 2'b01;
        tick();
        arvalid_m = 2'b00;
        arready = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; arvalid_m = 2'b01; araddr_m = {32'ha00003f8, 32'h80000000};
        rready_m = 2'b00; arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;
        repeat (2) tick();
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_arready_m", arready_m, 2'b00);
        chk("rst_rvalid_m", rvalid_m, 2'b00);
        arvalid_m = 2'b00;
        rst = 1'b0;
        tick();

        // round-robin from reset: IFU, LSU, IFU
        xact("tie1", 2'b11, 2'b01, 32'h80000000, 32'h11111111);
        xact("tie2", 2'b11, 2'b10, 32'ha00003f8, 32'h22222222);
        xact("tie3", 2'b11, 2'b01, 32'h80000000, 32'h33333333);
        xact("ifu_only", 2'b01, 2'b01, 32'h80000000, 32'h00000413);
        xact("lsu_only", 2'b10, 2'b10, 32'ha00003f8, 32'hcafef00d);

        // stray slave beat in IDLE is swallowed
        rvalid = 1'b1; rdata = 32'h5a5a5a5a;
        #1 chk("idle_rready", rready, 1'b1);
        chk("idle_drop", rvalid_m, 2'b00);
        tick();
        rvalid = 1'b0;

        // master backpressure for 4 cycles
        to_data_ifu();
        rvalid = 1'b1; rdata = 32'hdeadbeef; rresp = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1 chk("bp_rready", rready, 1'b0);
            chk("bp_rvalid_m", rvalid_m, 2'b01);
            chk("bp_rdata_m", rdata_m, 32'hdeadbeef);
            chk("bp_gnt", gnt, 2'b01);
            tick();
        end
        rready_m = 2'b01;
        #1 chk("bp_release", rready, 1'b1);
        chk("bp_rresp_m", rresp_m, 2'b01);
        tick();
        rvalid = 1'b0; rready_m = 2'b00; rresp = 2'b00;
        #1 chk("bp_done", gnt, 2'b00);

        // async reset mid-DATA, between clock edges
        to_data_ifu();
        rvalid = 1'b1; rdata = 32'h12345678; rready_m = 2'b00; arvalid_m = 2'b10;
        #2 rst = 1'b1;
        #1;
        chk("arst_gnt", gnt, 2'b00);
        chk("arst_arvalid", arvalid, 1'b0);
        chk("arst_araddr", araddr, 32'h0);
        chk("arst_rvalid_m", rvalid_m, 2'b00);
        chk("arst_arready_m", arready_m, 2'b00);
        tick();
        rst = 1'b0; rvalid = 1'b0; arvalid_m = 2'b00;
        tick();
        xact("post_rst_lsu", 2'b10, 2'b10, 32'ha00003f8, 32'h0badc0de);
        xact("post_rst_tie", 2'b11, 2'b01, 32'h80000000, 32'h0000beef);

        // silent slave: error response on the 8th DATA cycle when timeout is built in
        to_data_ifu();
        rready_m = 2'b01; rdata = 32'hffffffff; rresp = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            #1 chk("tmo_rvalid_m", rvalid_m, (TMO && i == 8) ? 2'b01 : 2'b00);
            if (i == 8) begin
                chk("tmo_rresp_m", rresp_m, TMO ? 2'b11 : 2'b00);
                chk("tmo_rdata_m", rdata_m, TMO ? 32'h0 : 32'hffffffff);
                chk("tmo_rready", rready, TMO ? 1'b0 : 1'b1);
            end else begin
                tick();
            end
        end
        if (!TMO) rvalid = 1'b1;
        tick();
        rvalid = 1'b1;
        #1 chk("late_drop", rvalid_m, 2'b00);
        chk("late_rready", rready, 1'b1);
        chk("late_gnt", gnt, 2'b00);
        tick();
        rvalid = 1'b0; rready_m = 2'b00;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
